// File: rtl/ex_stage_mem_reg.sv
// ex_stage_mem_reg: miniRV execute stage (ALU, branch/jump redirect) plus EX/MEM register with stall/flush and trace counters
module ex_stage_mem_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             have_inst_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [3:0]       alu_op_i,
  input  logic             alub_sel_i,
  input  logic [XLEN-1:0]  rD1_i,
  input  logic [XLEN-1:0]  rD2_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [XLEN-1:0]  pcimm_i,
  input  logic [2:0]       branch_i,
  input  logic [1:0]       jump_i,
  input  logic [1:0]       wd_sel_i,
  input  logic             rf_we_i,
  input  logic             dram_we_i,
  input  logic [4:0]       wR_i,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [XLEN-1:0]  alu_res_o,
  output logic [XLEN-1:0]  wD_o,
  output logic [XLEN-1:0]  st_data_o,
  output logic [1:0]       wd_sel_o,
  output logic             rf_we_o,
  output logic             dram_we_o,
  output logic [4:0]       wR_o,
  output logic [XLEN-1:0]  pc_o,
  output logic             have_inst_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] tk_cnt_o
);
  logic [XLEN-1:0] b, alu, jalr_sum, target, wd;
  logic [4:0] sh;
  logic br_cond, jmp, take, is_br;
  assign b = alub_sel_i ? imm_i : rD2_i;
  assign sh = b[4:0];
  always_comb begin
    alu = '0;
    case (alu_op_i)
      4'd0: alu = rD1_i + b;
      4'd1: alu = rD1_i - b;
      4'd2: alu = rD1_i & b;
      4'd3: alu = rD1_i | b;
      4'd4: alu = rD1_i ^ b;
      4'd5: alu = rD1_i << sh;
      4'd6: alu = rD1_i >> sh;
      4'd7: alu = $signed(rD1_i) >>> sh;
      4'd8: alu = {{(XLEN-1){1'b0}}, $signed(rD1_i) < $signed(b)};
      4'd9: alu = {{(XLEN-1){1'b0}}, rD1_i < b};
      4'd10: alu = b;
      default: alu = '0;
    endcase
  end
  always_comb begin
    br_cond = 1'b0;
    case (branch_i)
      3'd1: br_cond = rD1_i == rD2_i;
      3'd2: br_cond = rD1_i != rD2_i;
      3'd3: br_cond = $signed(rD1_i) < $signed(rD2_i);
      3'd4: br_cond = $signed(rD1_i) >= $signed(rD2_i);
      3'd5: br_cond = rD1_i < rD2_i;
      3'd6: br_cond = rD1_i >= rD2_i;
      default: br_cond = 1'b0;
    endcase
  end
  assign jmp = jump_i == 2'd1 || jump_i == 2'd2;
  assign jalr_sum = rD1_i + imm_i;
  assign target = jump_i == 2'd2 ? (jalr_sum & ~XLEN'(1)) : pcimm_i;
  assign take = have_inst_i & (jmp | br_cond);
  assign redirect_o = take & ~stall_i & ~rst;
  assign redirect_pc_o = take ? target : '0;
  assign is_br = have_inst_i && branch_i != 3'd0 && branch_i != 3'd7;
  assign wd = wd_sel_i == 2'd0 ? alu : wd_sel_i == 2'd1 ? '0 : wd_sel_i == 2'd2 ? pc_i + XLEN'(4) : imm_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_res_o   <= '0;
      wD_o        <= '0;
      st_data_o   <= '0;
      wd_sel_o    <= '0;
      rf_we_o     <= 1'b0;
      dram_we_o   <= 1'b0;
      wR_o        <= '0;
      pc_o        <= '0;
      have_inst_o <= 1'b0;
      br_cnt_o    <= '0;
      tk_cnt_o    <= '0;
    end else if (!stall_i) begin
      alu_res_o   <= alu;
      wD_o        <= wd;
      st_data_o   <= rD2_i;
      wR_o        <= wR_i;
      wd_sel_o    <= flush_i ? 2'd0 : wd_sel_i;
      rf_we_o     <= ~flush_i & rf_we_i;
      dram_we_o   <= ~flush_i & dram_we_i;
      pc_o        <= flush_i ? '0 : pc_i;
      have_inst_o <= ~flush_i & have_inst_i;
      br_cnt_o    <= br_cnt_o + CNT_W'(is_br);
      tk_cnt_o    <= tk_cnt_o + CNT_W'(redirect_o);
    end
  end
endmodule

// File: tb/tb_ex_stage_mem_reg.sv
// tb_ex_stage_mem_reg: directed plus random checks of ex_stage_mem_reg against a behavioural model
module tb_ex_stage_mem_reg;
  logic clk = 1'b0;
  logic rst, stall, flush, have_inst, alub_sel, rf_we, dram_we;
  logic [31:0] pc, rD1, rD2, imm, pcimm;
  logic [3:0] alu_op;
  logic [2:0] branch;
  logic [1:0] jump, wd_sel;
  logic [4:0] wr;
  logic redirect_o, rf_we_o, dram_we_o, have_inst_o;
  logic [31:0] redirect_pc_o, alu_res_o, wD_o, st_data_o, pc_o, br_cnt_o, tk_cnt_o;
  logic [1:0] wd_sel_o;
  logic [4:0] wR_o;
  logic [31:0] e_alu, e_wd, e_st, e_pc, e_br, e_tk;
  logic [1:0] e_wdsel;
  logic [4:0] e_wr;
  logic e_rfwe, e_dwe, e_hi;
  int checks = 0, failures = 0;

  ex_stage_mem_reg dut (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .have_inst_i(have_inst),
    .pc_i(pc), .alu_op_i(alu_op), .alub_sel_i(alub_sel), .rD1_i(rD1), .rD2_i(rD2),
    .imm_i(imm), .pcimm_i(pcimm), .branch_i(branch), .jump_i(jump), .wd_sel_i(wd_sel),
    .rf_we_i(rf_we), .dram_we_i(dram_we), .wR_i(wr),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .alu_res_o(alu_res_o),
    .wD_o(wD_o), .st_data_o(st_data_o), .wd_sel_o(wd_sel_o), .rf_we_o(rf_we_o),
    .dram_we_o(dram_we_o), .wR_o(wR_o), .pc_o(pc_o), .have_inst_o(have_inst_o),
    .br_cnt_o(br_cnt_o), .tk_cnt_o(tk_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] exp, input logic [63:0] obs);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    s = b % 32;
    case (op)
      0: return a + b;
      1: return a + ~b + 1;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << s;
      6: return a >> s;
      7: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      8: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      9: return (a < b) ? 32'd1 : 32'd0;
      10: return b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_br(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    bit lt_s, lt_u;
    lt_s = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    lt_u = a < b;
    case (t)
      1: return a == b;
      2: return a != b;
      3: return lt_s;
      4: return !lt_s;
      5: return lt_u;
      6: return !lt_u;
      default: return 1'b0;
    endcase
  endfunction

  task automatic clear();
    {stall, flush, have_inst, alub_sel, rf_we, dram_we} = '0;
    {pc, rD1, rD2, imm, pcimm} = '0;
    alu_op = 0; branch = 0; jump = 0; wd_sel = 0; wr = 0;
  endtask

  task automatic step();
    logic [31:0] b, res, tgt, wd;
    bit take, red, cnt_br;
    #1;
    b = alub_sel ? imm : rD2;
    res = m_alu(alu_op, rD1, b);
    take = have_inst && (jump == 1 || jump == 2 || m_br(branch, rD1, rD2));
    tgt = jump == 2 ? ((rD1 + imm) & 32'hFFFF_FFFE) : pcimm;
    red = take && !stall && !rst;
    cnt_br = have_inst && branch >= 1 && branch <= 6;
    chk("redirect", red, redirect_o);
    chk("redirect_pc", take ? tgt : 0, redirect_pc_o);
    wd = wd_sel == 0 ? res : wd_sel == 1 ? 0 : wd_sel == 2 ? pc + 4 : imm;
    @(posedge clk);
    #1;
    if (rst) begin
      {e_alu, e_wd, e_st, e_pc, e_br, e_tk} = '0;
      {e_wdsel, e_wr, e_rfwe, e_dwe, e_hi} = '0;
    end else if (!stall) begin
      e_alu = res; e_wd = wd; e_st = rD2; e_wr = wr;
      e_wdsel = flush ? 0 : wd_sel;
      e_rfwe = !flush && rf_we;
      e_dwe = !flush && dram_we;
      e_pc = flush ? 0 : pc;
      e_hi = !flush && have_inst;
      e_br = e_br + (cnt_br ? 1 : 0);
      e_tk = e_tk + (red ? 1 : 0);
    end
    chk("alu_res", e_alu, alu_res_o);
    chk("wD", e_wd, wD_o);
    chk("st_data", e_st, st_data_o);
    chk("wd_sel", e_wdsel, wd_sel_o);
    chk("rf_we", e_rfwe, rf_we_o);
    chk("dram_we", e_dwe, dram_we_o);
    chk("wR", e_wr, wR_o);
    chk("pc", e_pc, pc_o);
    chk("have_inst", e_hi, have_inst_o);
    chk("br_cnt", e_br, br_cnt_o);
    chk("tk_cnt", e_tk, tk_cnt_o);
  endtask

  initial begin
    {e_alu, e_wd, e_st, e_pc, e_br, e_tk} = '0;
    {e_wdsel, e_wr, e_rfwe, e_dwe, e_hi} = '0;
    rst = 1; stall = 0; flush = 0; have_inst = 1; alub_sel = 1; rf_we = 1; dram_we = 1;
    pc = 32'h10; rD1 = 32'h5; rD2 = 32'h5; imm = 32'h7; pcimm = 32'h17;
    alu_op = 1; branch = 1; jump = 1; wd_sel = 3; wr = 5'd9;
    step();
    step();
    chk("rst_have_inst", 0, have_inst_o);
    chk("rst_tk_cnt", 0, tk_cnt_o);
    rst = 0;
    clear();
    rD1 = 32'h7FFF_FFFF; rD2 = 1; alu_op = 0; have_inst = 1; rf_we = 1; wr = 5'd3;
    step();
    chk("add_const", 32'h8000_0000, alu_res_o);
    chk("add_wd_const", 32'h8000_0000, wD_o);
    rD1 = 32'h8000_0000; imm = 4; alub_sel = 1; alu_op = 7;
    step();
    chk("sra_const", 32'hF800_0000, alu_res_o);
    clear();
    have_inst = 1; branch = 3; rD1 = 32'hFFFF_FFFF; rD2 = 1; pcimm = 32'h100;
    step();
    chk("blt_tk_const", 1, tk_cnt_o);
    branch = 5;
    step();
    chk("bltu_br_const", 2, br_cnt_o);
    chk("bltu_tk_const", 1, tk_cnt_o);
    clear();
    have_inst = 1; jump = 2; rD1 = 32'h1003; imm = 0; pc = 32'h40; wd_sel = 2;
    step();
    chk("jalr_wd_const", 32'h44, wD_o);
    clear();
    have_inst = 1; branch = 1; rD1 = 32'h55; rD2 = 32'h55; pcimm = 32'h200; stall = 1;
    repeat (3) step();
    stall = 0;
    step();
    chk("stall_release_tk", 3, tk_cnt_o);
    clear();
    have_inst = 1; rf_we = 1; dram_we = 1; wd_sel = 2; pc = 32'h80; flush = 1; rD2 = 32'hABCD; wr = 5'd7;
    step();
    stall = 1; rD2 = 32'h1234; wr = 5'd8;
    step();
    chk("flush_stall_hold", 32'hABCD, st_data_o);
    stall = 0; flush = 0;
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 31) == 0;
      stall = $urandom_range(0, 3) == 0;
      flush = $urandom_range(0, 3) == 0;
      have_inst = $urandom_range(0, 7) != 0;
      alub_sel = 1'($urandom);
      rf_we = 1'($urandom);
      dram_we = 1'($urandom);
      pc = $urandom & 32'hFFFF_FFFC;
      rD1 = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
      rD2 = $urandom_range(0, 3) == 0 ? rD1 : $urandom;
      imm = $urandom;
      pcimm = $urandom;
      alu_op = 4'($urandom);
      branch = 3'($urandom);
      jump = $urandom_range(0, 2) == 0 ? 2'($urandom) : 2'd0;
      wd_sel = 2'($urandom);
      wr = 5'($urandom);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_stage_mem_reg.md
Name: ex_stage_mem_reg

Overview:
- Execute stage of the 5-stage miniRV pipeline, directly downstream of the ID/EX register; consumes its outputs.
- Computes the ALU result, resolves branches and jumps, and issues the redirect/flush to IF and ID.
- Registers EX results into the EX/MEM pipeline register, with stall and flush.
- Keeps two 32-bit trace counters: resolved branches and taken redirects.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 32, trace counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- stall_i  in  1  hold the EX/MEM register (downstream memory busy).
- flush_i  in  1  insert a bubble into EX/MEM.
- have_inst_i  in  1  valid instruction in EX.
- pc_i  in  32  PC of the EX instruction.
- alu_op_i  in  4  ALU opcode.
- alub_sel_i  in  1  ALU B operand select: 0 = rD2, 1 = imm.
- rD1_i  in  32  forwarded operand A.
- rD2_i  in  32  forwarded operand B / store data.
- imm_i  in  32  immediate.
- pcimm_i  in  32  pc + imm, precomputed in ID.
- branch_i  in  3  branch type.
- jump_i  in  2  jump type.
- wd_sel_i  in  2  writeback select.
- rf_we_i  in  1  register-file write enable.
- dram_we_i  in  1  data-memory write enable.
- wR_i  in  5  destination register.
- redirect_o  out  1  combinational; take the new PC this cycle.
- redirect_pc_o  out  32  combinational; target PC.
- alu_res_o  out  32  registered ALU result / memory address.
- wD_o  out  32  registered early writeback value.
- st_data_o  out  32  registered store data.
- wd_sel_o  out  2  registered.
- rf_we_o  out  1  registered.
- dram_we_o  out  1  registered.
- wR_o  out  5  registered.
- pc_o  out  32  registered.
- have_inst_o  out  1  registered.
- br_cnt_o  out  CNT_W  resolved-branch count.
- tk_cnt_o  out  CNT_W  taken-redirect count.

Behaviour:
- Operand selection: A = rD1_i; B = alub_sel_i ? imm_i : rD2_i.
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is B[4:0].
  - 8 SLT (signed, result 0 or 1), 9 SLTU (unsigned, result 0 or 1).
  - 10 PASSB.
  - 11–15 give result 0.
- All arithmetic is modulo 2^32; no overflow flag.
- branch encoding, compares rD1_i against rD2_i (never imm):
  - 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 treated as none.
  - Taken branch target = pcimm_i.
- jump encoding:
  - 0 none.
  - 1 JAL: target pcimm_i.
  - 2 JALR: target (rD1_i + imm_i) & ~1.
  - 3 treated as none.
- Jump has priority over branch if both are nonzero.
- Redirect:
  - take = have_inst_i & (jump taken | branch condition true).
  - redirect_o = take & ~stall_i & ~rst.
  - redirect_pc_o = target when take, else 0.
  - Fully combinational; the same-cycle PC load and the IF/ID and ID/EX flush are driven from redirect_o.
- wD_o value captured at the edge, by wd_sel_i:
  - 0: ALU result.
  - 1: 0 (filled by MEM).
  - 2: pc_i + 4.
  - 3: imm_i.
- EX/MEM register update at each rising edge, in priority order:
  1. rst: every registered output goes to 0, including both counters.
  2. stall_i: every register holds; the counters also hold.
  3. flush_i: have_inst_o, rf_we_o, dram_we_o, wd_sel_o and pc_o go to 0; data fields (alu_res_o, wD_o, st_data_o, wR_o) still load the new values.
  4. Otherwise every field loads from the EX inputs; st_data_o loads rD2_i.
- When stall_i and flush_i are both high, stall wins; the flush must be re-asserted by the controller.
- A redirect is independent of flush_i: the redirecting instruction itself still enters EX/MEM unless flush_i is high.
- Counters advance only on edges where rst=0 and stall_i=0:
  - br_cnt_o increments when have_inst_i and branch_i is 1–6.
  - tk_cnt_o increments when redirect_o is high.
  - Both wrap from 2^CNT_W−1 to 0.
  - A flush_i cycle still counts.
- Reset mid-operation: a pending redirect is dropped, outputs clear on the edge, and no counter increments on that edge.
- Latency: redirect 0 cycles (combinational); EX/MEM outputs 1 cycle.

Test Plan:
- Reset with all inputs nonzero, rst=1 for 2 cycles: every registered output is 0, redirect_o=0.
- ADD: rD1=0x7FFFFFFF, rD2=1, alub_sel=0, alu_op=0, wd_sel=0 → next cycle alu_res_o=0x80000000, wD_o=0x80000000, redirect_o=0. SRA of 0x80000000 by imm=4 (alub_sel=1) → 0xF8000000.
- Branches:
  - BLT rD1=0xFFFFFFFF, rD2=1, pcimm=0x100 → redirect_o=1, redirect_pc_o=0x100, br_cnt +1, tk_cnt +1.
  - BLTU with the same operands → redirect_o=0, br_cnt +1, tk_cnt unchanged.
- JALR: rD1=0x1003, imm=0, pc=0x40, wd_sel=2 → redirect_pc_o=0x1002; wD_o=0x44 next cycle.
- stall_i=1 for 3 cycles while a BEQ-taken instruction sits in EX → redirect_o=0, EX/MEM and counters frozen; on release, redirect_o=1 for one cycle and tk_cnt +1.
- flush_i=1 together with rf_we=1, dram_we=1 → have_inst_o=0, rf_we_o=0, dram_we_o=0. flush_i and stall_i both high → all registers hold.
